// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch front end for a single-cycle core.
// Owns the fetch PC, issues word requests to instruction memory, buffers the
// in-order responses together with their PCs in a DEPTH-entry FIFO and hands
// them to decode over a valid/ready channel. A redirect flushes the FIFO,
// marks every in-flight response for discard and restarts fetch at the target.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     request handshake to instruction memory
//   imem_req_addr            word-aligned fetch address
//   imem_rsp_valid/data      in-order instruction responses
//   instr_valid/ready        head-of-queue handshake to the core
//   instr, instr_pc          head instruction word and its PC
//   redirect, redirect_pc    flush and restart fetch at redirect_pc
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h1000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   // one extra bit so credit sums never overflow
   localparam int unsigned SW = CW + 1;

   logic [31:0]   q_data [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] live_inflight;
   logic [CW-1:0] discard_cnt;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;

   logic credit_ok;
   logic req_fire;
   logic rsp_any;
   logic rsp_drop;
   logic rsp_live;
   logic deq;
   logic [31:0] redirect_base;

   // Requests are limited both by queue space (so a live response always
   // finds a free slot) and by the total of outstanding responses.
   assign credit_ok = ((SW'(count) + SW'(live_inflight)) < SW'(DEPTH)) &&
                      ((SW'(live_inflight) + SW'(discard_cnt)) < SW'(DEPTH));

   assign imem_req_valid = !rst && !redirect && credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign instr_valid    = (count != '0) && !redirect;
   assign instr          = q_data[rd_ptr];
   assign instr_pc       = q_pc[rd_ptr];

   assign req_fire      = imem_req_valid && imem_req_ready;
   assign rsp_drop      = imem_rsp_valid && (discard_cnt != '0);
   assign rsp_live      = imem_rsp_valid && (discard_cnt == '0) && (live_inflight != '0);
   assign rsp_any       = rsp_drop || rsp_live;
   assign deq           = instr_valid && instr_ready;
   assign redirect_base = {redirect_pc[31:2], 2'b00};

   // Fetch state, credits and FIFO storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc      <= RESET_PC;
         rsp_pc        <= RESET_PC;
         count         <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         live_inflight <= '0;
         discard_cnt   <= '0;
         q_data        <= '{default: '0};
         q_pc          <= '{default: '0};
      end else if (redirect) begin
         fetch_pc      <= redirect_base;
         rsp_pc        <= redirect_base;
         count         <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         live_inflight <= '0;
         // every outstanding response becomes stale; one arriving now is
         // already consumed
         discard_cnt   <= discard_cnt + live_inflight - CW'(rsp_any);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (rsp_drop) begin
            discard_cnt <= discard_cnt - CW'(1);
         end
         if (rsp_live) begin
            q_data[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
            wr_ptr         <= wr_ptr + AW'(1);
            rsp_pc         <= rsp_pc + 32'd4;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count         <= count + CW'(rsp_live) - CW'(deq);
         live_inflight <= live_inflight + CW'(req_fire) - CW'(rsp_live);
      end
   end

   // A response with nothing outstanding is a memory protocol violation.
   always_ff @(posedge clk) begin
      if (!rst && imem_rsp_valid && (discard_cnt == '0) && (live_inflight == '0)) begin
         $error("instr_fetch_queue: response with no request outstanding");
      end
   end

endmodule
